mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
Load/store initiator between the single-cycle datapath and the word-only data memory (`dmem`). It turns byte, halfword and word requests into word accesses on the `dmem` interface. Sub-word stores use read-modify-write; loads are extracted and sign/zero extended. It flags misaligned, out-of-range or reserved-size requests without touching memory. One request is in flight at a time, with a valid/ready request side and a one-cycle response pulse.

Parameters:
ADDR_WORDS_LOG2, 6, log2 of dmem depth in words; byte addresses >= 4<<ADDR_WORDS_LOG2 are out of range

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept (high only in IDLE)
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data (0 for stores/errors)
resp_err  out  1  request rejected, no memory access made
mem_we  out  1  dmem write enable
mem_a  out  32  dmem byte address, always word-aligned (low 2 bits 0)
mem_wd  out  32  dmem write data
mem_rd  in  32  dmem combinational read data for mem_a

Behaviour:
- Reset: async, clears state to IDLE. resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0. All latched request and data registers=0, so mem_a=0.
- Accept: a request is taken on a rising edge with req_valid && req_ready. Addr, we, size, unsigned and wdata are latched. req_ready is 0 outside IDLE; inputs are ignored outside IDLE.
- Error check at accept:
  - size=11 -> error.
  - half with addr[0]=1 -> error.
  - word with addr[1:0]!=0 -> error.
  - addr[31:ADDR_WORDS_LOG2+2]!=0 -> error.
- States:
  - IDLE:
    - accept with error -> RESP with err=1.
    - accept otherwise -> ACCESS.
  - ACCESS: mem_a = {latched addr[31:2],2'b00}.
    - word store: mem_we=1, mem_wd=wdata -> RESP.
    - load: extract from mem_rd, extend, register into resp_rdata -> RESP.
    - sub-word store: register mem_rd into a merge buffer -> MERGE.
  - MERGE: mem_a unchanged, mem_we=1, mem_wd = merge buffer with the addressed lane replaced by wdata -> RESP.
  - RESP: resp_valid=1 for exactly this cycle, resp_err as latched -> IDLE.
- Latency, counted from the accept edge to the resp_valid cycle:
  - error: 1 cycle.
  - load and word store: 2 cycles.
  - sub-word store: 3 cycles.
  - No back-to-back overlap; the next accept is possible at the edge ending RESP+IDLE.
- Byte lanes are big-endian (MIPS):
  - byte offset 0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
  - half offset 0 -> [31:16], 2 -> [15:0].
- mem_we is decoded from state only and is never high in IDLE or RESP. Exactly one write cycle per store, and none for loads or errors.
- Reset mid-operation: the in-flight request is dropped. No write follows reset assertion, including from MERGE, and no resp_valid is produced.
- resp_rdata and resp_err hold their values until the next RESP; they are only meaningful while resp_valid=1.

Decomposition:
- Shared package `lsu_pkg` holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD;
  - the state enum IDLE/ACCESS/MERGE/RESP.
- Natural sub-module `lsu_lane`: combinational. Given offset, size and unsigned, it produces the extended load value and the merged store word.

Test Plan:
- Word round trip: store word 0xDEADBEEF @0x10, then load word @0x10 -> mem_we high one cycle with mem_a=0x10, mem_wd=0xDEADBEEF; load resp_rdata=0xDEADBEEF, resp_err=0, resp_valid 2 cycles after accept.
- Byte store RMW: word 0x11223344 @0x20, store byte 0xAA @0x21 -> one write of 0x11AA3344 in MERGE, resp_valid 3 cycles after accept; then load word @0x20 returns 0x11AA3344.
- Sign/zero extend: word 0x80FF7F01 @0x30:
  - load byte signed @0x30 -> 0xFFFFFF80;
  - load byte unsigned @0x31 -> 0x000000FF;
  - load half signed @0x32 -> 0x00007F01.
- Errors:
  - load word @0x06 -> resp_err=1 one cycle after accept, mem_we never 1, resp_rdata=0.
  - same result for half @0x05, size=11, and addr 0x100 with default ADDR_WORDS_LOG2=6.
- Reset mid-op: assert reset during MERGE of byte store @0x21 -> mem_we falls to 0 immediately, no write, memory word unchanged, no resp_valid, req_ready=1 after release.
- Handshake: hold req_valid high with a stream of 3 loads -> req_ready low outside IDLE, each request accepted exactly once, in order, 3 responses.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: request size codes and FSM states.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        MERGE,
        RESP
    } state_e;

endpackage

// File: rtl/lsu_lane.sv
// Big-endian byte-lane steering: load extraction with sign/zero extension and
// sub-word merge of store data into a previously read memory word.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  offset_i,
    input  size_e       size_i,
    input  logic        unsigned_i,
    input  logic [31:0] rd_word_i,
    input  logic [31:0] merge_word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merge_data_o
);

    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Offset 0 is the most significant lane, so the shift shrinks as offset grows.
    assign byte_shift = {~offset_i, 3'b000};
    assign half_shift = offset_i[1] ? 5'd0 : 5'd16;
    assign byte_val   = 8'(rd_word_i >> byte_shift);
    assign half_val   = 16'(rd_word_i >> half_shift);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        load_data_o  = rd_word_i;
        merge_data_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                load_data_o  = unsigned_i ? {24'd0, byte_val}
                                          : {{24{byte_val[7]}}, byte_val};
                merge_data_o = (merge_word_i & ~(32'h0000_00FF << byte_shift))
                             | ({24'd0, wdata_i[7:0]} << byte_shift);
            end
            SZ_HALF: begin
                load_data_o  = unsigned_i ? {16'd0, half_val}
                                          : {{16{half_val[15]}}, half_val};
                merge_data_o = (merge_word_i & ~(32'h0000_FFFF << half_shift))
                             | ({16'd0, wdata_i[15:0]} << half_shift);
            end
            default: begin
                load_data_o  = rd_word_i;
                merge_data_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator: converts byte/half/word requests into word-only dmem
// accesses, using read-modify-write for sub-word stores.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_WORDS_LOG2 = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    size_e       size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] merge_q, merge_d;

    logic        accept;
    logic        req_err;
    size_e       req_size_e;
    logic [31:0] lane_load;
    logic [31:0] lane_merge;

    assign req_size_e = size_e'(req_size);
    assign accept     = req_valid && (state_q == IDLE);

    // Rejected requests never reach ACCESS, so memory is untouched for them.
    assign req_err = (req_size_e == SZ_RSVD)
                  || ((req_size_e == SZ_HALF) && req_addr[0])
                  || ((req_size_e == SZ_WORD) && (req_addr[1:0] != 2'b00))
                  || ((req_addr >> (ADDR_WORDS_LOG2 + 2)) != 32'd0);

    lsu_lane u_lane (
        .offset_i     (addr_q[1:0]),
        .size_i       (size_q),
        .unsigned_i   (uns_q),
        .rd_word_i    (mem_rd),
        .merge_word_i (merge_q),
        .wdata_i      (wdata_q),
        .load_data_o  (lane_load),
        .merge_data_o (lane_merge)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        merge_d = merge_q;
        mem_we  = 1'b0;
        mem_wd  = wdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    size_d  = req_size_e;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    err_d   = req_err;
                    rdata_d = 32'd0;
                    state_d = req_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    rdata_d = lane_load;
                    state_d = RESP;
                end else if (size_q == SZ_WORD) begin
                    mem_we  = 1'b1;
                    state_d = RESP;
                end else begin
                    merge_d = mem_rd;
                    state_d = MERGE;
                end
            end
            MERGE: begin
                mem_we  = 1'b1;
                mem_wd  = lane_merge;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // mem_we is decoded combinationally from registered state, so an async reset
    // drops it immediately, even mid-MERGE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            merge_q <= 32'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            merge_q <= merge_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_a      = {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed vector table, reset/handshake
// sequences and randomized requests against a byte-array reference model.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_lsu #(.ADDR_WORDS_LOG2(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_we       (mem_we),
        .mem_a        (mem_a),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd)
    );

    // Word-wide data memory with combinational read.
    logic [31:0] dmem [64];
    int          wr_cnt = 0;
    int          resp_cnt = 0;
    logic [31:0] last_wa = 32'd0;
    logic [31:0] last_wd = 32'd0;

    assign mem_rd = dmem[mem_a[7:2]];

    initial begin
        for (int i = 0; i < 64; i++) dmem[i] = 32'd0;
        forever begin
            @(posedge clk);
            if (mem_we) begin
                dmem[mem_a[7:2]] <= mem_wd;
                wr_cnt++;
                last_wa = mem_a;
                last_wd = mem_wd;
            end
            if (resp_valid) resp_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Reference: memory as a flat big-endian byte array.
    logic [7:0] ref_bytes [256];

    task automatic ref_model(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic err, output int lat,
                             output int wr, output logic [31:0] wd);
        int nb;
        int a;
        logic [31:0] v;
        err   = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
                (size == 2'd2 && addr[1:0] != 2'd0) || (addr > 32'd255);
        rdata = 32'd0;
        wr    = 0;
        wd    = 32'd0;
        lat   = 1;
        if (!err) begin
            nb = 1 << size;
            a  = int'(addr[7:0]);
            if (we) begin
                for (int k = 0; k < nb; k++) ref_bytes[a + k] = 8'(wdata >> (8 * (nb - 1 - k)));
                a   = a & ~3;
                wd  = {ref_bytes[a], ref_bytes[a + 1], ref_bytes[a + 2], ref_bytes[a + 3]};
                wr  = 1;
                lat = (nb == 4) ? 2 : 3;
            end else begin
                v = 32'd0;
                for (int k = 0; k < nb; k++) v = (v << 8) | {24'd0, ref_bytes[a + k]};
                if (!uns && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
                if (!uns && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
                rdata = v;
                lat   = 2;
            end
        end
    endtask

    // Issue one request from IDLE and observe its response.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int wr, output logic [31:0] wa, output logic [31:0] wd);
        int w0;
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) check("ready_timeout", {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        w0           = wr_cnt;
        @(posedge clk);
        lat   = 0;
        rdata = 32'd0;
        err   = 1'b0;
        while (lat < 8) begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
            if (resp_valid) begin
                rdata = resp_rdata;
                err   = resp_err;
                break;
            end
        end
        if (!resp_valid) lat = 99;
        wr = wr_cnt - w0;
        wa = last_wa;
        wd = last_wd;
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wr;
        logic [31:0] exp_wd;
    } vec_t;

    function automatic vec_t mk(string name, logic we, logic [1:0] size, logic uns,
                                logic [31:0] addr, logic [31:0] wdata, logic [31:0] exp_rdata,
                                logic exp_err, int exp_lat, int exp_wr, logic [31:0] exp_wd);
        vec_t v;
        v.name = name; v.we = we; v.size = size; v.uns = uns; v.addr = addr;
        v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        v.exp_lat = exp_lat; v.exp_wr = exp_wr; v.exp_wd = exp_wd;
        return v;
    endfunction

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    initial begin
        logic [31:0] rdata, wa, wd, e_rdata, e_wd, hs_exp [3], hs_addr [3];
        logic        err, e_err;
        int          lat, wr, e_lat, e_wr, w0, r0, idx, got, ready_cycles;

        vecs[0]  = mk("st_w_10",  1, 2'd2, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0, 2, 1, 32'hDEADBEEF);
        vecs[1]  = mk("ld_w_10",  0, 2'd2, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0, 2, 0, 32'h0);
        vecs[2]  = mk("st_w_20",  1, 2'd2, 0, 32'h20,  32'h11223344, 32'h0,        0, 2, 1, 32'h11223344);
        vecs[3]  = mk("st_b_21",  1, 2'd0, 0, 32'h21,  32'h000000AA, 32'h0,        0, 3, 1, 32'h11AA3344);
        vecs[4]  = mk("ld_w_20",  0, 2'd2, 0, 32'h20,  32'h0,        32'h11AA3344, 0, 2, 0, 32'h0);
        vecs[5]  = mk("st_w_30",  1, 2'd2, 0, 32'h30,  32'h80FF7F01, 32'h0,        0, 2, 1, 32'h80FF7F01);
        vecs[6]  = mk("ldb_s_30", 0, 2'd0, 0, 32'h30,  32'h0,        32'hFFFFFF80, 0, 2, 0, 32'h0);
        vecs[7]  = mk("ldb_u_31", 0, 2'd0, 1, 32'h31,  32'h0,        32'h000000FF, 0, 2, 0, 32'h0);
        vecs[8]  = mk("ldh_s_32", 0, 2'd1, 0, 32'h32,  32'h0,        32'h00007F01, 0, 2, 0, 32'h0);
        vecs[9]  = mk("ldh_s_30", 0, 2'd1, 0, 32'h30,  32'h0,        32'hFFFF80FF, 0, 2, 0, 32'h0);
        vecs[10] = mk("sth_12",   1, 2'd1, 0, 32'h12,  32'hFFFF1234, 32'h0,        0, 3, 1, 32'hDEAD1234);
        vecs[11] = mk("ldb_s_13", 0, 2'd0, 0, 32'h13,  32'h0,        32'h00000034, 0, 2, 0, 32'h0);
        vecs[12] = mk("err_w_06", 0, 2'd2, 0, 32'h06,  32'h0,        32'h0,        1, 1, 0, 32'h0);
        vecs[13] = mk("err_h_05", 0, 2'd1, 0, 32'h05,  32'h0,        32'h0,        1, 1, 0, 32'h0);
        vecs[14] = mk("err_rsvd", 0, 2'd3, 0, 32'h40,  32'h0,        32'h0,        1, 1, 0, 32'h0);
        vecs[15] = mk("err_oob",  0, 2'd2, 0, 32'h100, 32'h0,        32'h0,        1, 1, 0, 32'h0);
        vecs[16] = mk("err_stoob",1, 2'd0, 0, 32'h100, 32'hAA,       32'h0,        1, 1, 0, 32'h0);
        vecs[17] = mk("st_b_ff",  1, 2'd0, 0, 32'hFF,  32'h5A,       32'h0,        0, 3, 1, 32'h0000005A);
        vecs[18] = mk("ldb_s_ff", 0, 2'd0, 0, 32'hFF,  32'h0,        32'h0000005A, 0, 2, 0, 32'h0);

        for (int i = 0; i < 256; i++) ref_bytes[i] = 8'd0;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err",   {31'd0, resp_err}, 32'd0);
        check("rst_mem_we",     {31'd0, mem_we}, 32'd0);
        check("rst_mem_a",      mem_a, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("rst_req_ready",  {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < NVEC; i++) begin
            do_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                   rdata, err, lat, wr, wa, wd);
            ref_model(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                      e_rdata, e_err, e_lat, e_wr, e_wd);
            check({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
            check({vecs[i].name, "_err"},   {31'd0, err}, {31'd0, vecs[i].exp_err});
            check({vecs[i].name, "_lat"},   32'(lat), 32'(vecs[i].exp_lat));
            check({vecs[i].name, "_writes"}, 32'(wr), 32'(vecs[i].exp_wr));
            if (vecs[i].exp_wr != 0) begin
                check({vecs[i].name, "_wd"}, wd, vecs[i].exp_wd);
                check({vecs[i].name, "_wa"}, wa, vecs[i].addr & 32'hFFFF_FFFC);
            end
        end

        // Reset asserted while a byte store sits in MERGE.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h21; req_wdata = 32'h55;
        w0 = wr_cnt; r0 = resp_cnt;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid_we_in_merge", {31'd0, mem_we}, 32'd1);
        reset = 1'b1;
        #1;
        check("rstmid_we_dropped", {31'd0, mem_we}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rstmid_no_resp", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("rstmid_ready", {31'd0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        check("rstmid_no_write", 32'(wr_cnt - w0), 32'd0);
        check("rstmid_no_resp_cnt", 32'(resp_cnt - r0), 32'd0);
        check("rstmid_mem_word", dmem[8], 32'h11AA3344);

        // Streamed loads with req_valid held high.
        hs_addr[0] = 32'h10; hs_addr[1] = 32'h20; hs_addr[2] = 32'h30;
        for (int k = 0; k < 3; k++) ref_model(0, 2'd2, 0, hs_addr[k], 32'd0, hs_exp[k], e_err, e_lat, e_wr, e_wd);
        idx = 0; got = 0; ready_cycles = 0; r0 = resp_cnt;
        for (int c = 0; c < 40 && got < 3; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                check($sformatf("hs_rdata_%0d", got), resp_rdata, hs_exp[got]);
                got++;
            end
            if (req_ready) ready_cycles++;
            if (idx < 3) begin
                req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
                req_addr = hs_addr[idx]; req_wdata = 32'd0;
                if (req_ready) idx++;
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        check("hs_accepts", 32'(idx), 32'd3);
        check("hs_responses", 32'(got), 32'd3);
        check("hs_ready_cycles", 32'(ready_cycles), 32'd3);
        @(negedge clk);
        check("hs_resp_cnt", 32'(resp_cnt - r0), 32'd3);

        // Randomized requests against the reference model.
        for (int n = 0; n < 80; n++) begin
            logic        r_we, r_uns;
            logic [1:0]  r_size;
            logic [31:0] r_addr, r_wdata;
            int          sel;
            r_we    = 1'($urandom_range(0, 1));
            r_uns   = 1'($urandom_range(0, 1));
            sel     = $urandom_range(0, 9);
            r_size  = (sel < 3) ? 2'(sel) : ((sel < 9) ? 2'd2 : 2'd3);
            r_addr  = 32'($urandom_range(0, 255));
            if (r_size == 2'd1 && $urandom_range(0, 3) != 0) r_addr[0] = 1'b0;
            if (r_size == 2'd2 && $urandom_range(0, 3) != 0) r_addr[1:0] = 2'b00;
            if ($urandom_range(0, 9) == 0) r_addr = r_addr | (32'd1 << $urandom_range(8, 31));
            r_wdata = $urandom;
            ref_model(r_we, r_size, r_uns, r_addr, r_wdata, e_rdata, e_err, e_lat, e_wr, e_wd);
            do_req(r_we, r_size, r_uns, r_addr, r_wdata, rdata, err, lat, wr, wa, wd);
            check($sformatf("rnd%0d_rdata", n), rdata, e_rdata);
            check($sformatf("rnd%0d_err", n), {31'd0, err}, {31'd0, e_err});
            check($sformatf("rnd%0d_lat", n), 32'(lat), 32'(e_lat));
            check($sformatf("rnd%0d_writes", n), 32'(wr), 32'(e_wr));
            if (e_wr != 0) begin
                check($sformatf("rnd%0d_wd", n), wd, e_wd);
                check($sformatf("rnd%0d_wa", n), wa, r_addr & 32'hFFFF_FFFC);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
